// File: rtl/rom_stream_capture_ctrl_pkg.sv
// Shared constants for the ROM stream capture controller: widths, depths and FSM state encoding.
package rom_stream_capture_ctrl_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_DEPTH  = 16;
  localparam int unsigned DEF_ADDR_W = $clog2(DEF_DEPTH);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CAPTURE  = 2'd1;
  localparam logic [1:0] ST_READBACK = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

endpackage

// File: rtl/rom_stream_capture_ctrl_if.sv
// Bus between the ROM stream source/observer and the capture controller.
interface rom_stream_capture_ctrl_if
  import rom_stream_capture_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_done;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   word_count;
  logic [DATA_W-1:0] checksum;
  logic              overflow;
  logic              done;

  modport master (
    output in_valid, in_data, in_done,
    input  out_valid, out_data, word_count, checksum, overflow, done
  );

  modport slave (
    input  in_valid, in_data, in_done,
    output out_valid, out_data, word_count, checksum, overflow, done
  );

endinterface

// File: rtl/rom_stream_capture_ctrl_single_port_ram.sv
// Single-port RAM with one shared address, write enable and registered (1-cycle) read data.
module rom_stream_capture_ctrl_single_port_ram
  import rom_stream_capture_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end

endmodule

// File: rtl/rom_stream_capture_ctrl.sv
// Captures a ROM word stream into RAM with a running checksum, then replays it and pulses done.
module rom_stream_capture_ctrl
  import rom_stream_capture_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic clk,
  input  logic rst,
  rom_stream_capture_ctrl_if.slave bus
);

  localparam int unsigned        CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]   FULL  = CNT_W'(DEPTH);

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  word_count_q, wc_nxt;
  logic [CNT_W-1:0]  rd_cnt, rd_cnt_nxt;
  logic [DATA_W-1:0] checksum_q, cks_nxt;
  logic              overflow_q, ovf_nxt;
  logic              out_valid_q, out_valid_nxt;
  logic              done_q, done_nxt;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      word_count_q <= '0;
      rd_cnt       <= '0;
      checksum_q   <= '0;
      overflow_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      word_count_q <= wc_nxt;
      rd_cnt       <= rd_cnt_nxt;
      checksum_q   <= cks_nxt;
      overflow_q   <= ovf_nxt;
      out_valid_q  <= out_valid_nxt;
      done_q       <= done_nxt;
    end
  end

  // Next-state and RAM port control; the one RAM address serves writes in capture, reads in readback.
  always_comb begin
    state_nxt     = state;
    wc_nxt        = word_count_q;
    rd_cnt_nxt    = rd_cnt;
    cks_nxt       = checksum_q;
    ovf_nxt       = overflow_q;
    out_valid_nxt = 1'b0;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;

    case (state)
      ST_IDLE: begin
        rd_cnt_nxt = '0;
        if (bus.in_valid) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          wc_nxt    = CNT_W'(1);
          cks_nxt   = bus.in_data;
          ovf_nxt   = 1'b0;
          state_nxt = bus.in_done ? ST_READBACK : ST_CAPTURE;
        end else if (bus.in_done) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_CAPTURE: begin
        if (bus.in_valid) begin
          if (word_count_q < FULL) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = word_count_q[ADDR_W-1:0];
            wc_nxt   = word_count_q + CNT_W'(1);
            cks_nxt  = checksum_q + bus.in_data;
          end else begin
            ovf_nxt = 1'b1;
          end
        end
        if (bus.in_done) state_nxt = ST_READBACK;
      end
      ST_READBACK: begin
        // Read data lands one cycle after the address, so out_valid is the delayed read strobe.
        if (rd_cnt < word_count_q) begin
          ram_en        = 1'b1;
          ram_addr      = rd_cnt[ADDR_W-1:0];
          out_valid_nxt = 1'b1;
          rd_cnt_nxt    = rd_cnt + CNT_W'(1);
        end else begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    done_nxt = (state_nxt == ST_FLUSH);
  end

  rom_stream_capture_ctrl_single_port_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (bus.in_data),
    .rdata (ram_rdata)
  );

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = ram_rdata;
  assign bus.word_count = word_count_q;
  assign bus.checksum   = checksum_q;
  assign bus.overflow   = overflow_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_rom_stream_capture_ctrl.sv
// Directed bench for rom_stream_capture_ctrl: capture, overflow, empty stream, coincident done, reset, ignored input.
module tb_rom_stream_capture_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_q [$];

  rom_stream_capture_ctrl_if bus ();

  rom_stream_capture_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_done();
    bus.in_done = 1'b1;
    step();
    bus.in_done = 1'b0;
  endtask

  // Called one sample after the edge that took in_done; expects exp_q on consecutive cycles, then done.
  task automatic expect_replay(input string tag, input int n);
    check({tag, "_lat_ov"}, 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s_ov%0d", tag, i), 32'(bus.out_valid), 32'd1);
      check($sformatf("%s_od%0d", tag, i), 32'(bus.out_data), 32'(exp_q[i]));
      check($sformatf("%s_nd%0d", tag, i), 32'(bus.done), 32'd0);
    end
    step();
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_end_ov"}, 32'(bus.out_valid), 32'd0);
    step();
    check({tag, "_done_clr"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_done  = 1'b0;
    #250 rst = 1'b1;
    #10  rst = 1'b0;
    step();
    check("rst_ov",  32'(bus.out_valid),  32'd0);
    check("rst_od",  32'(bus.out_data),   32'd0);
    check("rst_wc",  32'(bus.word_count), 32'd0);
    check("rst_cks", 32'(bus.checksum),   32'd0);
    check("rst_ovf", 32'(bus.overflow),   32'd0);
    check("rst_dn",  32'(bus.done),       32'd0);

    // Five words 1..5
    for (int i = 1; i <= 5; i++) send_word(16'(i));
    pulse_done();
    check("s1_wc",  32'(bus.word_count), 32'd5);
    check("s1_cks", 32'(bus.checksum),   32'h000F);
    check("s1_ovf", 32'(bus.overflow),   32'd0);
    exp_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    expect_replay("s1", 5);
    check("s1_wc_hold", 32'(bus.word_count), 32'd5);

    // Seventeen words into a 16-deep RAM
    for (int i = 0; i < 17; i++) send_word(16'h1000);
    pulse_done();
    check("s2_wc",  32'(bus.word_count), 32'd16);
    check("s2_cks", 32'(bus.checksum),   32'h0000);
    check("s2_ovf", 32'(bus.overflow),   32'd1);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(16'h1000);
    expect_replay("s2", 16);

    // Empty stream
    pulse_done();
    check("s3_done", 32'(bus.done),      32'd1);
    check("s3_ov",   32'(bus.out_valid), 32'd0);
    check("s3_ovf_hold", 32'(bus.overflow), 32'd1);
    step();
    check("s3_done_clr", 32'(bus.done),      32'd0);
    check("s3_ov2",      32'(bus.out_valid), 32'd0);

    // Last word coincident with in_done
    send_word(16'h0002);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    bus.in_done  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_done  = 1'b0;
    check("s4_wc",  32'(bus.word_count), 32'd2);
    check("s4_cks", 32'(bus.checksum),   32'h0001);
    check("s4_ovf", 32'(bus.overflow),   32'd0);
    exp_q = '{16'h0002, 16'hFFFF};
    expect_replay("s4", 2);

    // Reset during the third replay cycle
    for (int i = 0; i < 4; i++) send_word(16'h00A0 + 16'(i));
    pulse_done();
    check("s5_lat_ov", 32'(bus.out_valid), 32'd0);
    step();
    check("s5_od0", 32'(bus.out_data), 32'h00A0);
    step();
    check("s5_od1", 32'(bus.out_data), 32'h00A1);
    step();
    check("s5_ov2", 32'(bus.out_valid), 32'd1);
    check("s5_od2", 32'(bus.out_data),  32'h00A2);
    rst = 1'b1;
    #1;
    check("s5_rst_ov", 32'(bus.out_valid), 32'd0);
    check("s5_rst_dn", 32'(bus.done),      32'd0);
    step();
    check("s5_rst_dn2", 32'(bus.done),       32'd0);
    check("s5_rst_wc",  32'(bus.word_count), 32'd0);
    rst = 1'b0;
    step();
    check("s5_post_dn", 32'(bus.done), 32'd0);
    send_word(16'h1234);
    send_word(16'h4321);
    pulse_done();
    check("s5_wc",  32'(bus.word_count), 32'd2);
    check("s5_cks", 32'(bus.checksum),   32'h5555);
    exp_q = '{16'h1234, 16'h4321};
    expect_replay("s5r", 2);

    // in_valid held during replay is ignored
    send_word(16'h0010);
    send_word(16'h0020);
    send_word(16'h0030);
    pulse_done();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hDEAD;
    exp_q = '{16'h0010, 16'h0020, 16'h0030};
    expect_replay("s6", 3);
    bus.in_valid = 1'b0;
    check("s6_wc",  32'(bus.word_count), 32'd3);
    check("s6_cks", 32'(bus.checksum),   32'h0060);
    check("s6_ovf", 32'(bus.overflow),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
